// File: rtl/img_mem_arbiter_pkg.sv
// Shared types and widths for the image RAM arbiter (display / clear / loader).
package img_mem_arbiter_pkg;

    localparam int IMG_ADDR_W = 16;
    localparam int IMG_DATA_W = 8;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_CLEAR = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_DISP  = 2'd1,
        GNT_CLEAR = 2'd2,
        GNT_LOAD  = 2'd3
    } gnt_t;

endpackage

// File: rtl/img_mem_arbiter_if.sv
// Display fetch, loader write and RAM macro signals of the image RAM arbiter.
interface img_mem_arbiter_if
    import img_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = IMG_ADDR_W,
    parameter int DATA_W = IMG_DATA_W
);

    logic              disp_req_i;
    logic [ADDR_W-1:0] disp_addr_i;
    logic [DATA_W-1:0] disp_data_o;
    logic              disp_valid_o;
    logic              wr_valid_i;
    logic              wr_ready_o;
    logic [ADDR_W-1:0] wr_addr_i;
    logic [DATA_W-1:0] wr_data_i;
    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;

    modport master (
        input  disp_req_i, disp_addr_i, wr_valid_i, wr_addr_i, wr_data_i, mem_rdata_i,
        output disp_data_o, disp_valid_o, wr_ready_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport slave (
        output disp_req_i, disp_addr_i, wr_valid_i, wr_addr_i, wr_data_i, mem_rdata_i,
        input  disp_data_o, disp_valid_o, wr_ready_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

endinterface

// File: rtl/img_mem_arbiter_clear_seq.sv
// Clear address walker with last-address detect and a one-cycle done pulse.
// Only instantiated when IMG_ARB_CLEAR_EN is defined.
module img_clear_seq
    import img_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = IMG_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o,
    output logic              done_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              done_q, done_d;

    assign last_o = (addr_q == {ADDR_W{1'b1}});
    assign addr_o = addr_q;
    assign done_o = done_q;

    // Next address: restart on start, advance on each granted clear write, stop after the top word.
    always_comb begin
        addr_d = addr_q;
        done_d = 1'b0;
        if (start_i) begin
            addr_d = {ADDR_W{1'b0}};
        end else if (step_i) begin
            done_d = last_o;
            if (last_o) begin
                addr_d = {ADDR_W{1'b0}};
            end else begin
                addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
        end else begin
            addr_d = addr_q;
        end
    end

    // Counter and done pulse registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q <= {ADDR_W{1'b0}};
            done_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            done_q <= done_d;
        end
    end

endmodule

// File: rtl/img_mem_arbiter.sv
// Single-port image RAM arbiter: display reads (never stalled) > clear engine > loader writes.
// The clear engine is built only when IMG_ARB_CLEAR_EN is defined.
module img_mem_arbiter
    import img_mem_arbiter_pkg::*;
#(
    parameter int                ADDR_W    = IMG_ADDR_W,
    parameter int                DATA_W    = IMG_DATA_W,
    parameter logic [DATA_W-1:0] CLEAR_VAL = {DATA_W{1'b0}}
) (
    input  logic                clk_i,
    input  logic                rst_i,
    img_mem_arbiter_if.master   bus,
    input  logic                clr_start_i,
    output logic                busy_o,
    output logic                clr_done_o
);

    logic              clear_active_s;
    logic [ADDR_W-1:0] clr_addr_s;
    logic              wr_ready_s;
    gnt_t              gnt_s;

    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              rd_issue_q, rd_issue_d;
    logic              rd_ret_q, rd_ret_d;
    logic              disp_valid_q, disp_valid_d;
    logic [DATA_W-1:0] disp_data_q, disp_data_d;

`ifdef IMG_ARB_CLEAR_EN
    arb_state_t state_q, state_d;
    logic       clr_start_s;
    logic       clr_step_s;
    logic       clr_last_s;
    logic       clr_done_s;

    assign clear_active_s = (state_q == ARB_CLEAR);
    assign clr_start_s    = (state_q == ARB_IDLE) & clr_start_i;
    assign clr_step_s     = clear_active_s & ~bus.disp_req_i;

    img_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (clr_start_s),
        .step_i  (clr_step_s),
        .addr_o  (clr_addr_s),
        .last_o  (clr_last_s),
        .done_o  (clr_done_s)
    );

    // Clear FSM next state; leaves CLEAR once the top address write is granted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (clr_start_i) begin
                    state_d = ARB_CLEAR;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_CLEAR: begin
                if (clr_step_s && clr_last_s) begin
                    state_d = ARB_IDLE;
                end else begin
                    state_d = ARB_CLEAR;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Clear FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign busy_o     = clear_active_s;
    assign clr_done_o = clr_done_s;
`else
    logic unused_clr_start_s;

    assign unused_clr_start_s = clr_start_i;
    assign clear_active_s     = 1'b0;
    assign clr_addr_s         = {ADDR_W{1'b0}};
    assign busy_o             = 1'b0;
    assign clr_done_o         = 1'b0;
`endif

    assign wr_ready_s     = ~bus.disp_req_i & ~clear_active_s;
    assign bus.wr_ready_o = wr_ready_s;

    // Fixed priority grant for this cycle.
    always_comb begin
        gnt_s = GNT_NONE;
        if (bus.disp_req_i) begin
            gnt_s = GNT_DISP;
        end else if (clear_active_s) begin
            gnt_s = GNT_CLEAR;
        end else if (bus.wr_valid_i && wr_ready_s) begin
            gnt_s = GNT_LOAD;
        end else begin
            gnt_s = GNT_NONE;
        end
    end

    // RAM port command; address and write data hold on cycles without a grant.
    always_comb begin
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_issue_d  = 1'b0;
        case (gnt_s)
            GNT_DISP: begin
                mem_en_d   = 1'b1;
                mem_addr_d = bus.disp_addr_i;
                rd_issue_d = 1'b1;
            end
            GNT_CLEAR: begin
                mem_en_d    = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = clr_addr_s;
                mem_wdata_d = CLEAR_VAL;
            end
            GNT_LOAD: begin
                mem_en_d    = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = bus.wr_addr_i;
                mem_wdata_d = bus.wr_data_i;
            end
            GNT_NONE: begin
                mem_en_d = 1'b0;
            end
            default: begin
                mem_en_d = 1'b0;
            end
        endcase
    end

    // Read-valid pipe: issue, RAM return, output capture; data holds between results.
    always_comb begin
        rd_ret_d     = rd_issue_q;
        disp_valid_d = rd_ret_q;
        if (rd_ret_q) begin
            disp_data_d = bus.mem_rdata_i;
        end else begin
            disp_data_d = disp_data_q;
        end
    end

    // Port and read pipe registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= {ADDR_W{1'b0}};
            mem_wdata_q  <= {DATA_W{1'b0}};
            rd_issue_q   <= 1'b0;
            rd_ret_q     <= 1'b0;
            disp_valid_q <= 1'b0;
            disp_data_q  <= {DATA_W{1'b0}};
        end else begin
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rd_issue_q   <= rd_issue_d;
            rd_ret_q     <= rd_ret_d;
            disp_valid_q <= disp_valid_d;
            disp_data_q  <= disp_data_d;
        end
    end

    assign bus.mem_en_o     = mem_en_q;
    assign bus.mem_we_o     = mem_we_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_wdata_o  = mem_wdata_q;
    assign bus.disp_valid_o = disp_valid_q;
    assign bus.disp_data_o  = disp_data_q;

endmodule
